// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline status in / sequencing strobes out for the hazard controller.
// master = pipeline side driving status, slave = the controller.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_uses_rt;
   logic             id_jump;
   logic             ex_memread;
   logic [4:0]       ex_rt;
   logic             ex_branch_taken;
   logic             mem_req;
   logic             mem_ready;
   logic             pc_write;
   logic             ifid_write;
   logic             ifid_flush;
   logic             idex_bubble;
   logic             idex_flush;
   logic             exmem_hold;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_rs, id_rt, id_uses_rt, id_jump, ex_memread, ex_rt,
             ex_branch_taken, mem_req, mem_ready,
      input  pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush,
             exmem_hold, mem_timeout, stall_count
   );

   modport slave (
      input  id_rs, id_rt, id_uses_rt, id_jump, ex_memread, ex_rt,
             ex_branch_taken, mem_req, mem_ready,
      output pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush,
             exmem_hold, mem_timeout, stall_count
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller for the five-stage pipeline: Mealy strobes for PC,
// IF/ID, ID/EX, EX/MEM from load-use, branch/jump redirects and memory waits.
module pipeline_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 16
) (
   input logic                   clk,
   input logic                   reset,
   pipeline_hazard_ctrl_if.slave bus
);
   localparam int WC_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

   typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WC_W-1:0]  r_wait_cnt;
   logic [WC_W-1:0]  w_wait_nxt;
   logic             r_mem_timeout;
   logic [CNT_W-1:0] r_stall_cnt;

   logic w_load_use, w_mem_stall, w_frozen;
   logic w_pc_write, w_ifid_write, w_ifid_flush;
   logic w_idex_bubble, w_idex_flush, w_exmem_hold;

   assign w_load_use  = bus.ex_memread && (bus.ex_rt != 5'd0) &&
                        ((bus.ex_rt == bus.id_rs) ||
                         (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
   assign w_mem_stall = bus.mem_req && !bus.mem_ready;
   // Once waiting, only mem_ready releases the freeze; mem_req is not re-checked.
   assign w_frozen    = (r_state == MEM_WAIT) && !bus.mem_ready;

   always_comb begin
      w_state_nxt   = RUN;
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_ifid_flush  = 1'b0;
      w_idex_bubble = 1'b0;
      w_idex_flush  = 1'b0;
      w_exmem_hold  = 1'b0;
      if (!reset) begin
         w_state_nxt = RUN;
      end else if (w_frozen || w_mem_stall) begin
         w_exmem_hold = 1'b1;
         w_state_nxt  = MEM_WAIT;
      end else if (bus.ex_branch_taken) begin
         w_pc_write   = 1'b1;
         w_ifid_flush = 1'b1;
         w_idex_flush = 1'b1;
         w_state_nxt  = REDIRECT;
      end else if (r_state != REDIRECT && w_load_use) begin
         w_idex_bubble = 1'b1;
      end else if (r_state != REDIRECT && bus.id_jump) begin
         w_pc_write   = 1'b1;
         w_ifid_write = 1'b1;
         w_ifid_flush = 1'b1;
      end else begin
         w_pc_write   = 1'b1;
         w_ifid_write = 1'b1;
      end
   end

   always_comb begin
      w_wait_nxt = '0;
      if (w_frozen) begin
         w_wait_nxt = (r_wait_cnt == WC_MAX) ? r_wait_cnt : r_wait_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state       <= RUN;
         r_wait_cnt    <= '0;
         r_mem_timeout <= 1'b0;
         r_stall_cnt   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_nxt;
         if (w_frozen && (w_wait_nxt == WC_MAX)) r_mem_timeout <= 1'b1;
         if (!w_pc_write && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign bus.pc_write    = w_pc_write;
   assign bus.ifid_write  = w_ifid_write;
   assign bus.ifid_flush  = w_ifid_flush;
   assign bus.idex_bubble = w_idex_bubble;
   assign bus.idex_flush  = w_idex_flush;
   assign bus.exmem_hold  = w_exmem_hold;
   assign bus.mem_timeout = r_mem_timeout;
   assign bus.stall_count = r_stall_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed vectors; driver queues expected strobes per cycle, monitor checks on negedge.
module tb_pipeline_hazard_ctrl;
   localparam int CNT_W       = 4;
   localparam int MEM_TIMEOUT = 15;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;
   // strobe order: {pc_write, ifid_write, ifid_flush, idex_bubble, idex_flush, exmem_hold}
   localparam logic [5:0] NRM = 6'b110000;
   localparam logic [5:0] LU  = 6'b000100;
   localparam logic [5:0] BR  = 6'b101010;
   localparam logic [5:0] JMP = 6'b111000;
   localparam logic [5:0] FRZ = 6'b000001;
   localparam logic [5:0] OFF = 6'b000000;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus();
   pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   typedef struct {
      logic [5:0]       strb;
      int               to;   // 2 = don't care
      logic [CNT_W-1:0] cnt;
      string            name;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   exp_cnt = 0;

   task automatic step(input string nm, input logic rst, input logic [4:0] rs, rt,
                       input logic urt, jmp, mrd, input logic [4:0] ert,
                       input logic br, mreq, mrdy, input logic [5:0] strb,
                       input int to, input bit chk);
      exp_t e;
      @(posedge clk); #1;
      reset               = rst;
      bus.id_rs           = rs;
      bus.id_rt           = rt;
      bus.id_uses_rt      = urt;
      bus.id_jump         = jmp;
      bus.ex_memread      = mrd;
      bus.ex_rt           = ert;
      bus.ex_branch_taken = br;
      bus.mem_req         = mreq;
      bus.mem_ready       = mrdy;
      if (chk) begin
         e.strb = strb; e.to = to; e.cnt = exp_cnt[CNT_W-1:0]; e.name = nm;
         q.push_back(e);
      end
      if (!rst) exp_cnt = 0;
      else if (!strb[5] && exp_cnt < CNT_MAX) exp_cnt++;
   endtask

   initial begin
      exp_t       e;
      logic [5:0] act;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e   = q.pop_front();
            act = {bus.pc_write, bus.ifid_write, bus.ifid_flush,
                   bus.idex_bubble, bus.idex_flush, bus.exmem_hold};
            total++;
            if (act !== e.strb || bus.stall_count !== e.cnt ||
                (e.to != 2 && bus.mem_timeout !== e.to[0])) begin
               bad++;
               $display("FAIL %s: got strb=%b cnt=%0d to=%b, want strb=%b cnt=%0d to=%0d",
                        e.name, act, bus.stall_count, bus.mem_timeout,
                        e.strb, e.cnt, e.to);
            end
         end
      end
   end

   initial begin
      reset = 1'b0;
      bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rt = 1'b0; bus.id_jump = 1'b0;
      bus.ex_memread = 1'b0; bus.ex_rt = '0; bus.ex_branch_taken = 1'b0;
      bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
      //    name            rst rs rt u  j  mr ert br rq rd strobe to chk
      step("rst0",          0, 0, 0, 0, 0, 0, 0, 0, 1, 0, OFF, 2, 0);
      step("rst1",          0, 0, 0, 0, 0, 0, 0, 0, 1, 0, OFF, 0, 1);
      step("run",           1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 1);
      step("lu_rs",         1, 5, 0, 0, 0, 1, 5, 0, 0, 0, LU,  0, 1);
      step("lu_redecode",   1, 5, 0, 0, 0, 0, 5, 0, 0, 0, NRM, 0, 1);
      step("lu_rt0",        1, 0, 0, 0, 0, 1, 0, 0, 0, 0, NRM, 0, 1);
      step("lu_rt",         1, 3, 7, 1, 0, 1, 7, 0, 0, 0, LU,  0, 1);
      step("lu_rt_unused",  1, 3, 7, 0, 0, 1, 7, 0, 0, 0, NRM, 0, 1);
      step("br_lu",         1, 5, 0, 0, 0, 1, 5, 1, 0, 0, BR,  0, 1);
      step("redir_ignore",  1, 5, 0, 0, 1, 1, 5, 0, 0, 0, NRM, 0, 1);
      step("jump",          1, 0, 0, 0, 1, 0, 0, 0, 0, 0, JMP, 0, 1);
      for (int i = 0; i < 4; i++)
         step("memwait",    1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 1);
      step("memdone",       1, 0, 0, 0, 0, 0, 0, 0, 1, 1, NRM, 0, 1);
      step("rdy_noreq",     1, 0, 0, 0, 0, 0, 0, 0, 0, 1, NRM, 0, 1);
      step("mw_enter",      1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 1);
      step("mw_br_exit",    1, 0, 0, 0, 0, 0, 0, 1, 1, 1, BR,  0, 1);
      step("redir_mem",     1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 1);
      step("mw_ignore",     1, 5, 0, 0, 1, 1, 5, 1, 1, 0, FRZ, 0, 1);
      step("mw_lu_exit",    1, 5, 0, 0, 0, 1, 5, 0, 1, 1, LU,  0, 1);
      step("after_lu",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 1);
      step("rm_enter",      1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 1);
      step("rm_wait",       1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ, 0, 1);
      step("rm_reset",      0, 0, 0, 0, 0, 0, 0, 0, 1, 0, OFF, 0, 1);
      step("rm_run",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 1);
      for (int i = 0; i < 20; i++)
         step("tmo_wait",   1, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ,
              (i <= 13) ? 0 : ((i == 19) ? 1 : 2), 1);
      step("tmo_done",      1, 0, 0, 0, 0, 0, 0, 0, 1, 1, NRM, 1, 1);
      step("tmo_sticky",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 1, 1);
      step("tmo_rst0",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OFF, 1, 1);
      step("tmo_rst1",      0, 0, 0, 0, 0, 0, 0, 0, 0, 0, OFF, 0, 1);
      step("tmo_run",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NRM, 0, 1);
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         bad++;
         $display("FAIL drain: %0d expected entries never checked, want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and stall controller for the five-stage 32-bit pipeline. Sequences the IF/ID register, the PC and the ID/EX and EX/MEM registers by generating write-enable, flush, bubble and hold strobes. Covers load-use hazards, taken-branch and jump redirects, and multi-cycle data-memory waits. Sits beside the decode stage; its outputs feed the PC register, IF/ID, ID/EX and EX/MEM directly.

## Interface
- `MEM_TIMEOUT`, default 15: number of MEM_WAIT cycles after which `mem_timeout` sets.
- `CNT_W`, default 16: width of the stall performance counter.

- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-low
- `id_rs`  in  5  source register 1 of the instruction in ID
- `id_rt`  in  5  source register 2 of the instruction in ID
- `id_uses_rt`  in  1  ID instruction reads `rt`
- `id_jump`  in  1  ID instruction is an unconditional jump
- `ex_memread`  in  1  EX instruction is a load
- `ex_rt`  in  5  destination of the EX load
- `ex_branch_taken`  in  1  branch in EX resolved taken
- `mem_req`  in  1  MEM stage holds a load or store
- `mem_ready`  in  1  data memory completes the access this cycle
- `pc_write`  out  1  PC update enable
- `ifid_write`  out  1  IF/ID write enable
- `ifid_flush`  out  1  IF/ID loads the NOP encoding
- `idex_bubble`  out  1  ID/EX loads zero control (stall bubble)
- `idex_flush`  out  1  ID/EX flushed (wrong-path squash)
- `exmem_hold`  out  1  EX/MEM and MEM/WB hold their contents
- `mem_timeout`  out  1  sticky error: memory wait exceeded `MEM_TIMEOUT`
- `stall_count`  out  CNT_W  saturating count of cycles with `pc_write`=0

## Operation
- `load_use` = `ex_memread` && `ex_rt`!=0 && (`ex_rt`==`id_rs` || (`id_uses_rt` && `ex_rt`==`id_rt`)).
- `mem_stall` = `mem_req` && !`mem_ready`.
- Outputs are Mealy: they are combinational from the state and the current inputs. Decisions take effect at the next `clk` edge through the strobed registers.
- States: RUN, MEM_WAIT, REDIRECT. Priority, highest first: `mem_stall`, `ex_branch_taken`, `load_use`, `id_jump`, normal.
- In RUN, and in MEM_WAIT when `mem_ready`=1:
  - `mem_stall`: `pc_write`=0, `ifid_write`=0, `exmem_hold`=1. No flush or bubble. Next state is MEM_WAIT.
  - Branch taken: `pc_write`=1, `ifid_flush`=1, `idex_flush`=1. Next state is REDIRECT.
  - Load-use: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1. Next state is RUN.
  - Jump: `pc_write`=1, `ifid_write`=1, `ifid_flush`=1. Next state is RUN.
  - Normal: `pc_write`=1, `ifid_write`=1, all other strobes 0. Next state is RUN.
- In MEM_WAIT with `mem_ready`=0:
  - Full freeze: `pc_write`=0, `ifid_write`=0, `exmem_hold`=1. `ex_branch_taken`, `load_use` and `id_jump` are ignored.
  - `wait_cnt` increments, saturating at `MEM_TIMEOUT`. `wait_cnt` clears on leaving MEM_WAIT.
  - `mem_timeout` sets when `wait_cnt` reaches `MEM_TIMEOUT`. It clears only on reset. The controller keeps waiting.
- REDIRECT lasts one cycle, because ID holds the flushed NOP:
  - `load_use` and `id_jump` are ignored.
  - `mem_stall` and `ex_branch_taken` are evaluated as in RUN.
  - Next state is RUN unless one of those applies.
- `ifid_flush` has priority over `ifid_write` inside IF/ID. The controller never asserts `idex_bubble` and `idex_flush` together.
- `stall_count` increments on every non-reset cycle with `pc_write`=0 and saturates at all-ones.

## Timing
- Reset (`reset`=0 at a `clk` edge):
  - State becomes RUN; `wait_cnt`, `stall_count` and `mem_timeout` become 0.
  - While `reset`=0, all strobes are held at 0 (`pc_write`=0, `ifid_write`=0).
- Reset mid-MEM_WAIT abandons the wait and returns to RUN on the next edge.
- Load-use costs exactly 1 stall cycle: the dependent instruction re-decodes on the following cycle with `ex_memread`=0.
- Taken branch costs 2 squashed slots (IF/ID and ID/EX). A jump costs 1 (IF/ID).
- A memory wait of N cycles with `mem_ready`=0 costs N frozen cycles. On the cycle `mem_ready`=1, the pipeline advances.
- `mem_ready`=1 without `mem_req` is ignored.
- Simultaneous `ex_branch_taken` and `load_use`: the branch wins and the stalled instruction is squashed.

## Test plan
- Reset: hold `reset`=0 for 2 cycles with `mem_req`=1 -> all strobes 0, `stall_count`=0, `mem_timeout`=0. After release with no hazards, `pc_write`=`ifid_write`=1.
- Load-use: `ex_memread`=1, `ex_rt`=5, `id_rs`=5 -> exactly 1 cycle of `pc_write`=0, `ifid_write`=0, `idex_bubble`=1; `stall_count`=1. Repeat with `ex_rt`=0 -> no stall.
- Branch with load-use: `ex_branch_taken`=1 plus a load-use match -> `ifid_flush`=`idex_flush`=1, `idex_bubble`=0, `pc_write`=1. Next cycle (REDIRECT), `id_jump`=1 and a load-use match are ignored.
- Memory wait: `mem_req`=1, `mem_ready`=0 for 4 cycles, then 1 -> 4 frozen cycles with `exmem_hold`=1, then the pipeline advances; `stall_count`=4.
- Timeout: `mem_ready`=0 for 20 cycles with `MEM_TIMEOUT`=15 -> `mem_timeout` rises after the 15th wait cycle and stays 1 after `mem_ready`. A subsequent `reset`=0 clears it.
- Counter saturation: with `CNT_W`=4, force 20 stall cycles -> `stall_count`=15.
